// File: rtl/top.sv
// RGB LED colour-wheel fader: hue/brightness sequencer feeding three shadowed PWM channels.
// Define LED_ACTIVE_HIGH_EN for active-high pins (pin = lit, reset drives 0); default is active-low.
module top #(
    parameter int unsigned PWM_INTERVAL     = 1200,
    parameter int unsigned INC_DEC_INTERVAL = 10000,
    parameter int unsigned INC_DEC_MAX      = 200
) (
    input  logic clk,
    input  logic rst,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);
    localparam int unsigned STEP = PWM_INTERVAL / INC_DEC_MAX;
    localparam int unsigned DW   = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned PCW  = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int unsigned TCW  = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
    localparam int unsigned IW   = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

`ifdef LED_ACTIVE_HIGH_EN
    localparam logic PIN_OFF = 1'b0;
`else
    localparam logic PIN_OFF = 1'b1;
`endif

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} seg_t;

    logic [TCW-1:0] r_step_cnt;
    logic [IW-1:0]  r_index;
    seg_t           r_seg;
    seg_t           w_seg_next;
    logic           w_tick;

    logic [PCW-1:0] r_pwm_cnt;
    logic [DW-1:0]  r_shadow_r, r_shadow_g, r_shadow_b;
    logic [DW-1:0]  w_rise, w_fall;
    logic [DW-1:0]  w_lvl_r, w_lvl_g, w_lvl_b;
    logic [DW-1:0]  w_duty_r, w_duty_g, w_duty_b;
    logic           w_period_start;
    logic           r_pin_r, r_pin_g, r_pin_b;

    assign w_tick = (r_step_cnt == TCW'(INC_DEC_INTERVAL - 1));

    // Step timer, brightness index and hue segment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step_cnt <= '0;
            r_index    <= '0;
            r_seg      <= S0;
        end else if (w_tick) begin
            r_step_cnt <= '0;
            if (r_index == IW'(INC_DEC_MAX - 1)) begin
                r_index <= '0;
                r_seg   <= w_seg_next;
            end else begin
                r_index <= r_index + IW'(1);
            end
        end else begin
            r_step_cnt <= r_step_cnt + TCW'(1);
        end
    end

    always_comb begin
        w_seg_next = S0;
        case (r_seg)
            S0:      w_seg_next = S1;
            S1:      w_seg_next = S2;
            S2:      w_seg_next = S3;
            S3:      w_seg_next = S4;
            S4:      w_seg_next = S5;
            S5:      w_seg_next = S0;
            default: w_seg_next = S0;
        endcase
    end

    assign w_rise = DW'(32'(r_index) * STEP);
    assign w_fall = DW'(PWM_INTERVAL) - w_rise;

    // Per-segment channel levels around the hue circle.
    always_comb begin
        w_lvl_r = '0;
        w_lvl_g = '0;
        w_lvl_b = '0;
        case (r_seg)
            S0: begin w_lvl_r = DW'(PWM_INTERVAL); w_lvl_g = w_rise; end
            S1: begin w_lvl_r = w_fall; w_lvl_g = DW'(PWM_INTERVAL); end
            S2: begin w_lvl_g = DW'(PWM_INTERVAL); w_lvl_b = w_rise; end
            S3: begin w_lvl_g = w_fall; w_lvl_b = DW'(PWM_INTERVAL); end
            S4: begin w_lvl_r = w_rise; w_lvl_b = DW'(PWM_INTERVAL); end
            S5: begin w_lvl_r = DW'(PWM_INTERVAL); w_lvl_b = w_fall; end
            default: ;
        endcase
    end

    // At period start the fresh level is used directly so the new width covers the whole period.
    assign w_period_start = (r_pwm_cnt == '0);
    assign w_duty_r = w_period_start ? w_lvl_r : r_shadow_r;
    assign w_duty_g = w_period_start ? w_lvl_g : r_shadow_g;
    assign w_duty_b = w_period_start ? w_lvl_b : r_shadow_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_cnt  <= '0;
            r_shadow_r <= '0;
            r_shadow_g <= '0;
            r_shadow_b <= '0;
            r_pin_r    <= PIN_OFF;
            r_pin_g    <= PIN_OFF;
            r_pin_b    <= PIN_OFF;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == PCW'(PWM_INTERVAL - 1)) ? '0 : r_pwm_cnt + PCW'(1);
            if (w_period_start) begin
                r_shadow_r <= w_lvl_r;
                r_shadow_g <= w_lvl_g;
                r_shadow_b <= w_lvl_b;
            end
            r_pin_r <= (DW'(r_pwm_cnt) < w_duty_r) ^ PIN_OFF;
            r_pin_g <= (DW'(r_pwm_cnt) < w_duty_g) ^ PIN_OFF;
            r_pin_b <= (DW'(r_pwm_cnt) < w_duty_b) ^ PIN_OFF;
        end
    end

    assign RGB_R = r_pin_r;
    assign RGB_G = r_pin_g;
    assign RGB_B = r_pin_b;

endmodule

// File: tb/tb_top.sv
// Bench for the colour-wheel fader using scaled-down parameters and a closed-form
// expectation of every pin versus cycles elapsed since reset release.
module tb_top;
    localparam int unsigned PWM  = 24;
    localparam int unsigned INTV = 30;
    localparam int unsigned MAXI = 4;
    localparam int unsigned STEP = PWM / MAXI;

`ifdef LED_ACTIVE_HIGH_EN
    localparam logic OFF = 1'b0;
`else
    localparam logic OFF = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic RGB_R, RGB_G, RGB_B;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int lit_r, lit_g, lit_b;
    logic [2:0] q_exp[$];

    top #(
        .PWM_INTERVAL    (PWM),
        .INC_DEC_INTERVAL(INTV),
        .INC_DEC_MAX     (MAXI)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .RGB_R(RGB_R),
        .RGB_G(RGB_G),
        .RGB_B(RGB_B)
    );

    always #5 clk = ~clk;

    // Channel level (0=R,1=G,2=B) at time t cycles after release.
    function automatic int level(int t, int ch);
        int seg  = (t / (INTV * MAXI)) % 6;
        int idx  = (t / INTV) % MAXI;
        int rise = idx * STEP;
        int fall = PWM - rise;
        int r = 0, g = 0, b = 0;
        case (seg)
            0: begin r = PWM;  g = rise; end
            1: begin r = fall; g = PWM;  end
            2: begin g = PWM;  b = rise; end
            3: begin g = fall; b = PWM;  end
            4: begin r = rise; b = PWM;  end
            default: begin r = PWM; b = fall; end
        endcase
        return (ch == 0) ? r : (ch == 1) ? g : b;
    endfunction

    // Pins after edge kk: phase within period against the level latched at period start.
    function automatic logic [2:0] expect_pins(int kk);
        int ph = kk % PWM;
        int p  = kk - ph;
        logic [2:0] lit;
        lit[2] = (ph < level(p, 0));
        lit[1] = (ph < level(p, 1));
        lit[0] = (ph < level(p, 2));
        return lit ^ {3{OFF}};
    endfunction

    task automatic check_pins(string tag, logic [2:0] obs, logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: got %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(int n);
        logic [2:0] obs, e, lit;
        repeat (n) begin
            @(posedge clk);
            q_exp.push_back(expect_pins(k));
            k++;
            @(negedge clk);
            obs = {RGB_R, RGB_G, RGB_B};
            e   = q_exp.pop_front();
            check_pins("pins", obs, e);
            lit = obs ^ {3{OFF}};
            lit_r += int'(lit[2]);
            lit_g += int'(lit[1]);
            lit_b += int'(lit[0]);
        end
    endtask

    task automatic clear_counts();
        lit_r = 0;
        lit_g = 0;
        lit_b = 0;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_pins("reset_hold", {RGB_R, RGB_G, RGB_B}, {3{OFF}});
        end
        rst = 1'b1;
        k = 0;
        clear_counts();

        run_cycles(1);
        check_pins("release_red_on", {RGB_R, RGB_G, RGB_B}, 3'b100 ^ {3{OFF}});

        // S0 index 2: G at 2*STEP within the period starting at k=72.
        run_cycles(71);
        clear_counts();
        run_cycles(24);
        check_int("s0_lit_r", lit_r, PWM);
        check_int("s0_lit_g", lit_g, 2 * STEP);
        check_int("s0_lit_b", lit_b, 0);

        // S1 index 2: R falls to PWM-2*STEP, G full.
        run_cycles(96);
        clear_counts();
        run_cycles(24);
        check_int("s1_lit_r", lit_r, PWM - 2 * STEP);
        check_int("s1_lit_g", lit_g, PWM);
        check_int("s1_lit_b", lit_b, 0);

        // After a full wheel the S0 index 2 pattern repeats.
        run_cycles(576);
        clear_counts();
        run_cycles(24);
        check_int("wrap_lit_r", lit_r, PWM);
        check_int("wrap_lit_g", lit_g, 2 * STEP);
        check_int("wrap_lit_b", lit_b, 0);

        // Cover the S5->S0 wrap a second time and mid-sequence state.
        run_cycles(650);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_pins("async_reset", {RGB_R, RGB_G, RGB_B}, {3{OFF}});
        repeat (3) begin
            @(negedge clk);
            check_pins("reset_hold2", {RGB_R, RGB_G, RGB_B}, {3{OFF}});
        end
        rst = 1'b1;
        k = 0;
        run_cycles(1);
        check_pins("restart_red_on", {RGB_R, RGB_G, RGB_B}, 3'b100 ^ {3{OFF}});
        run_cycles(200);

        check_int("sb_empty", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/top.md
Name: top

Overview:
- FPGA top-level for an RGB LED colour-wheel fader.
- Walks the full HSV hue circle (360°, six 60° segments) once per 12,000,000 clock cycles (1 s at 12 MHz), then repeats indefinitely.
- Drives three PWM outputs straight to the board's active-low RGB LED pins.
- Contains a hue/brightness sequencer plus three PWM channels sharing one period counter.

Parameters:
- PWM_INTERVAL, 1200, PWM period in clock cycles; also the full-scale duty value.
- INC_DEC_INTERVAL, 10000, clock cycles between brightness steps.
- INC_DEC_MAX, 200, brightness steps per 60° hue segment.
- Derived, not overridable: STEP = PWM_INTERVAL / INC_DEC_MAX (default 6); integer division.

Ports:
- clk  input  1  system clock, 12 MHz nominal
- rst  input  1  asynchronous active-low reset
- RGB_R  output  1  red LED drive, active-low (0 = lit)
- RGB_G  output  1  green LED drive, active-low
- RGB_B  output  1  blue LED drive, active-low

Behaviour:
- Reset (rst=0, asynchronous):
  - All counters = 0; segment = S0.
  - All three outputs forced to 1 (LEDs off) for as long as rst is low.
- Step timer: counts 0..INC_DEC_INTERVAL-1 and wraps. Its terminal count produces a 1-cycle tick.
- Step index: 0..INC_DEC_MAX-1, advances on each tick.
  - On a tick with index = INC_DEC_MAX-1, index returns to 0 and the segment advances.
  - Segment order: S0→S1→S2→S3→S4→S5→S0.
- Segment length = INC_DEC_MAX × INC_DEC_INTERVAL cycles (2,000,000 at defaults).
- Channel levels, where rise = index×STEP and fall = PWM_INTERVAL − index×STEP:
  - S0: R = full, G = rise, B = 0
  - S1: R = fall, G = full, B = 0
  - S2: R = 0, G = full, B = rise
  - S3: R = 0, G = fall, B = full
  - S4: R = rise, G = 0, B = full
  - S5: R = full, G = 0, B = fall
  - full = PWM_INTERVAL. Duty width is ceil(log2(PWM_INTERVAL+1)) bits (11 at default); no overflow is possible.
- PWM counter: counts 0..PWM_INTERVAL-1 and wraps; free-running, independent of the step timer.
- Glitch-free duty update:
  - Each channel's duty is sampled into a shadow register when the PWM counter is at 0.
  - A mid-period level change takes effect at the next period start.
- Channel output:
  - Lit while pwm_count < shadow_duty. Duty 0 = never lit; duty PWM_INTERVAL = always lit.
  - Output pin = NOT lit.
  - Outputs are registered, so the pin reflects the compare result one cycle later.
- Reset release: the first shadow sample occurs on the first clock edge after release (pwm_count = 0). From then on, R is full on and G/B are off.
- Reset asserted mid-operation: immediate return to the reset state; no partial-period completion.
- Segment boundaries are continuous (e.g. S0 ends with G = 1194, then S1 starts with G = full = 1200), so there is no visible colour jump.

Optional Feature:
- Macro: LED_ACTIVE_HIGH_EN.
- Defined:
  - Outputs are active-high: pin = lit.
  - Reset drives all outputs to 0.
  - Intended for external LEDs or simulation probing.
- Undefined (default): active-low as described above; reset drives all outputs to 1.

Test Plan:
- Hold rst=0 for 10 cycles → RGB_R = RGB_G = RGB_B = 1 throughout. Release → within 2 cycles RGB_R = 0 continuously; RGB_G = RGB_B = 1.
- Run to cycle 1,000,000 (S0, index 100) → G duty 600: RGB_G low exactly 600 of each 1200-cycle period; RGB_R always low; RGB_B always high.
- Run to cycle 3,000,000 (S1, index 100) → R low 600 of 1200 cycles; G always low; B always high.
- Run 12,000,000 cycles → segment back to S0 with index 0: outputs identical to post-reset state. After 24,000,000 cycles (2 s), the sequence has repeated exactly twice.
- Change duty mid-period (observe at a step tick with pwm_count ≠ 0) → the current period's low-time is unchanged; the new width appears from the next pwm_count = 0.
- Assert rst at cycle 5,000,123 for 3 cycles → outputs go to 1 asynchronously (before the next clk edge); after release, the sequence restarts from S0 / index 0.
